// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg: shared constants for the instruction-fetch front end.
//   ENABLE/DISABLE  - single-bit control levels
//   RESET_ACTIVE    - level of the asynchronous reset input when asserted
//   INST_W          - instruction word width
//   PC_INC          - byte distance between sequential fetches
//   cnt_width()     - width of an occupancy counter able to hold 0..depth
package ifu_fetch_pkg;

  localparam logic ENABLE       = 1'b1;
  localparam logic DISABLE      = 1'b0;
  localparam logic RESET_ACTIVE = 1'b0;
  localparam int   INST_W       = 32;
  localparam int   PC_INC       = 4;

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// ifu_fetch_if: memory-side and decode-side buses of the fetch unit.
//   Memory bus : if2mem_req_o/if2mem_addr_o out, mem2if_gnt_i/rvalid_i/rdata_i in.
//   Decode bus : if2id_valid_o/inst_o/pc_o out, id2if_ready_i in.
//   master = fetch unit side, slave = memory/decode side.
interface ifu_fetch_if
  import ifu_fetch_pkg::*;
#(
  parameter int ADDR_W = 32
) ();

  logic              if2mem_req_o;
  logic [ADDR_W-1:0] if2mem_addr_o;
  logic              mem2if_gnt_i;
  logic              mem2if_rvalid_i;
  logic [INST_W-1:0] mem2if_rdata_i;
  logic              if2id_valid_o;
  logic [INST_W-1:0] if2id_inst_o;
  logic [ADDR_W-1:0] if2id_pc_o;
  logic              id2if_ready_i;

  modport master (
    output if2mem_req_o, if2mem_addr_o, if2id_valid_o, if2id_inst_o, if2id_pc_o,
    input  mem2if_gnt_i, mem2if_rvalid_i, mem2if_rdata_i, id2if_ready_i
  );

  modport slave (
    input  if2mem_req_o, if2mem_addr_o, if2id_valid_o, if2id_inst_o, if2id_pc_o,
    output mem2if_gnt_i, mem2if_rvalid_i, mem2if_rdata_i, id2if_ready_i
  );

endinterface

// File: rtl/ifu_fetch_fifo.sv
// ifu_fifo: synchronous FIFO with first-word fall-through read.
//   clk, rest      - clock, asynchronous active-low reset
//   clear          - synchronous flush (wins over push/pop)
//   push, wdata    - write when not full
//   pop            - discard head when not empty
//   rdata          - current head entry
//   full, empty    - occupancy flags
//   count          - number of stored entries (0..DEPTH)
module ifu_fifo
  import ifu_fetch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rest,
  input  logic                        clear,
  input  logic                        push,
  input  logic [WIDTH-1:0]            wdata,
  input  logic                        pop,
  output logic [WIDTH-1:0]            rdata,
  output logic                        full,
  output logic                        empty,
  output logic [cnt_width(DEPTH)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Flags and qualified transfers derived from the registered occupancy.
  always_comb begin
    full      = (count_r == CNT_W'(DEPTH));
    empty     = (count_r == {CNT_W{1'b0}});
    push_ok_s = push & ~full;
    pop_ok_s  = pop & ~empty;
    count     = count_r;
    rdata     = mem_r[rd_ptr_r];
  end

  // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk or negedge rest) begin
    if (rest == RESET_ACTIVE) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (clear) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      count_r <= count_r + CNT_W'(push_ok_s) - CNT_W'(pop_ok_s);
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch_chk: simulation-only protocol checks on the fetch unit internals.
//   rvalid must only arrive while a request is outstanding; neither queue may overflow.
module ifu_fetch_chk (
  input logic clk,
  input logic rest,
  input logic rvalid,
  input logic pcq_empty,
  input logic pcq_push,
  input logic pcq_full,
  input logic obuf_push,
  input logic obuf_full
);

  a_rvalid_with_outstanding: assert property (@(posedge clk) disable iff (!rest)
    !(rvalid && pcq_empty));
  a_pcq_no_overflow: assert property (@(posedge clk) disable iff (!rest)
    !(pcq_push && pcq_full));
  a_obuf_no_overflow: assert property (@(posedge clk) disable iff (!rest)
    !(obuf_push && obuf_full));

endmodule

// ifu_fetch: instruction-fetch front end and PC owner.
//   clk, rest          - clock, asynchronous active-low reset
//   cu2pc_jump_en_i    - redirect request from the control unit
//   ex2pc_jump_addr_i  - redirect target (low two bits ignored)
//   bus (master)       - req/gnt/rvalid memory bus and valid/ready IF/ID bus
// The in-flight PC queue remembers the address of every granted request, so its
// occupancy is the outstanding-request count. Responses for requests issued before
// a jump are counted off by drop_cnt_r and discarded.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h0000_0000),
  parameter int                DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rest,
  input  logic              cu2pc_jump_en_i,
  input  logic [ADDR_W-1:0] ex2pc_jump_addr_i,
  ifu_fetch_if.master       bus
);

  localparam int                CNT_W      = cnt_width(DEPTH);
  localparam int                BUF_W      = ADDR_W + INST_W;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  logic [ADDR_W-1:0] pc_r;
  logic [CNT_W-1:0]  drop_cnt_r;

  logic              jump_s;
  logic [ADDR_W-1:0] jump_tgt_s;
  logic              req_s;
  logic              issue_s;
  logic              pop_s;
  logic              rsp_s;
  logic              rsp_keep_s;
  logic              rsp_drop_s;
  logic [CNT_W:0]    used_s;

  logic [ADDR_W-1:0] pcq_head_s;
  logic              pcq_full_s;
  logic              pcq_empty_s;
  logic [CNT_W-1:0]  pcq_count_s;
  logic [BUF_W-1:0]  obuf_head_s;
  logic              obuf_full_s;
  logic              obuf_empty_s;
  logic [CNT_W-1:0]  obuf_count_s;

  // Transfer qualification and request credit; a same-cycle pop frees a slot.
  always_comb begin
    jump_s     = cu2pc_jump_en_i;
    jump_tgt_s = ex2pc_jump_addr_i & ALIGN_MASK;
    pop_s      = ~obuf_empty_s & bus.id2if_ready_i;
    // rvalid with nothing outstanding is ignored
    rsp_s      = bus.mem2if_rvalid_i & ~pcq_empty_s;
    rsp_drop_s = rsp_s & (drop_cnt_r != {CNT_W{1'b0}});
    // a response arriving in a jump cycle belongs to the abandoned stream
    rsp_keep_s = rsp_s & (drop_cnt_r == {CNT_W{1'b0}}) & ~jump_s;
    used_s     = {1'b0, pcq_count_s} + {1'b0, obuf_count_s} - (CNT_W+1)'(pop_s);
    if ((rest != RESET_ACTIVE) && !jump_s && (drop_cnt_r == {CNT_W{1'b0}}) &&
        (used_s < (CNT_W+1)'(DEPTH))) begin
      req_s = ENABLE;
    end else begin
      req_s = DISABLE;
    end
    issue_s = req_s & bus.mem2if_gnt_i;
  end

  // Bus outputs: request straight from the credit logic, IF/ID from the buffer head.
  always_comb begin
    bus.if2mem_req_o  = req_s;
    bus.if2mem_addr_o = pc_r;
    bus.if2id_valid_o = ~obuf_empty_s;
    if (obuf_empty_s) begin
      bus.if2id_inst_o = {INST_W{1'b0}};
      bus.if2id_pc_o   = {ADDR_W{1'b0}};
    end else begin
      bus.if2id_inst_o = obuf_head_s[INST_W-1:0];
      bus.if2id_pc_o   = obuf_head_s[BUF_W-1:INST_W];
    end
  end

  // Program counter: redirect on jump, advance by one word on each issue.
  always_ff @(posedge clk or negedge rest) begin
    if (rest == RESET_ACTIVE) begin
      pc_r <= RESET_PC;
    end else if (jump_s) begin
      pc_r <= jump_tgt_s;
    end else if (issue_s) begin
      pc_r <= pc_r + ADDR_W'(PC_INC);
    end else begin
      pc_r <= pc_r;
    end
  end

  // Drop counter: responses still owed to the old stream after a jump.
  always_ff @(posedge clk or negedge rest) begin
    if (rest == RESET_ACTIVE) begin
      drop_cnt_r <= {CNT_W{1'b0}};
    end else if (jump_s) begin
      drop_cnt_r <= pcq_count_s - CNT_W'(rsp_s);
    end else if (rsp_drop_s) begin
      drop_cnt_r <= drop_cnt_r - CNT_W'(1'b1);
    end else begin
      drop_cnt_r <= drop_cnt_r;
    end
  end

  ifu_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_pc_queue (
    .clk   (clk),
    .rest  (rest),
    .clear (DISABLE),
    .push  (issue_s),
    .wdata (pc_r),
    .pop   (rsp_s),
    .rdata (pcq_head_s),
    .full  (pcq_full_s),
    .empty (pcq_empty_s),
    .count (pcq_count_s)
  );

  ifu_fifo #(.WIDTH(BUF_W), .DEPTH(DEPTH)) u_out_buf (
    .clk   (clk),
    .rest  (rest),
    .clear (jump_s),
    .push  (rsp_keep_s),
    .wdata ({pcq_head_s, bus.mem2if_rdata_i}),
    .pop   (pop_s),
    .rdata (obuf_head_s),
    .full  (obuf_full_s),
    .empty (obuf_empty_s),
    .count (obuf_count_s)
  );

  ifu_fetch_chk u_chk (
    .clk       (clk),
    .rest      (rest),
    .rvalid    (bus.mem2if_rvalid_i),
    .pcq_empty (pcq_empty_s),
    .pcq_push  (issue_s),
    .pcq_full  (pcq_full_s),
    .obuf_push (rsp_keep_s),
    .obuf_full (obuf_full_s)
  );

endmodule
